uart_word_link: RTL and testbench

Full-duplex UART block that serialises a multi-byte word onto one 8N1 line and reassembles words from a second line. It sits between the register/datapath side and the board-level serial pins. Each word is sent as consecutive byte frames. The block is used in loopback (tx serial output tied to rx serial input) for bring-up.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_bit_timer.sv | 35 +++
 rtl/uart_word_link.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_uart_word_link.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, state encodings and helpers for the uart_word_link block.
// Build option: define UART_PARITY_EN to add an even-parity bit to every frame.
package uart_pkg;

`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP,
    TX_DONE
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Cycles from a start-bit edge to the middle of that start bit.
  function automatic int half_bits(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-period down-counter. tick is high while the count sits at
// zero, so reloading on every tick gives a period of exactly the loaded length.
// Build option UART_PARITY_EN does not affect this module.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic half,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(half_bits(CLKS_PER_BIT) - 1);

  logic [CW-1:0] cnt_reg;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= half ? HALF_LOAD : FULL_LOAD;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign tick = (cnt_reg == '0);

endmodule

// File: rtl/uart_word_link.sv
// Full-duplex word UART: serialises a WORD_BYTES-byte word as back-to-back
// 8N1 frames (byte 0 first, LSB first) and reassembles words from the rx line.
// Build option: define UART_PARITY_EN for even parity (8E1 frames).
module uart_word_link
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int WORD_BYTES   = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_tx_dv,
  input  logic [8*WORD_BYTES-1:0] i_tx_word,
  output logic                    o_tx_active,
  output logic                    o_tx_serial,
  output logic                    o_tx_done,
  input  logic                    i_rx_serial,
  output logic                    o_rx_dv,
  output logic [8*WORD_BYTES-1:0] o_rx_word
);

  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int BCW = $clog2(WORD_BYTES + 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(WORD_BYTES - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  // ---------------- transmit path ----------------
  tx_state_t tx_state_reg, tx_state_next;
  logic [WORD_W-1:0] tx_word_reg, tx_word_next;
  logic [2:0] tx_bit_reg, tx_bit_next;
  logic [BCW-1:0] tx_byte_reg, tx_byte_next;
  logic tx_serial_reg, tx_serial_next;
  logic tx_load, tx_tick;
`ifdef UART_PARITY_EN
  logic tx_par_reg, tx_par_next;
`endif

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .load  (tx_load),
    .half  (1'b0),
    .tick  (tx_tick)
  );

  // TX state and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_state_reg  <= TX_IDLE;
      tx_word_reg   <= '0;
      tx_bit_reg    <= '0;
      tx_byte_reg   <= '0;
      tx_serial_reg <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_reg    <= 1'b0;
`endif
    end else begin
      tx_state_reg  <= tx_state_next;
      tx_word_reg   <= tx_word_next;
      tx_bit_reg    <= tx_bit_next;
      tx_byte_reg   <= tx_byte_next;
      tx_serial_reg <= tx_serial_next;
`ifdef UART_PARITY_EN
      tx_par_reg    <= tx_par_next;
`endif
    end
  end

  // TX next state; the serial line is registered so the pin never glitches.
  // The word is shifted right one bit per data bit, so bit 0 is always next.
  always_comb begin
    tx_state_next  = tx_state_reg;
    tx_word_next   = tx_word_reg;
    tx_bit_next    = tx_bit_reg;
    tx_byte_next   = tx_byte_reg;
    tx_serial_next = tx_serial_reg;
    tx_load        = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_next    = tx_par_reg;
`endif
    case (tx_state_reg)
      TX_IDLE, TX_DONE: begin
        tx_state_next  = TX_IDLE;
        tx_serial_next = 1'b1;
        if (i_tx_dv) begin
          tx_state_next  = TX_START;
          tx_serial_next = 1'b0;
          tx_word_next   = i_tx_word;
          tx_byte_next   = '0;
          tx_load        = 1'b1;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_state_next  = TX_DATA;
          tx_serial_next = tx_word_reg[0];
          tx_bit_next    = '0;
          tx_load        = 1'b1;
`ifdef UART_PARITY_EN
          tx_par_next    = ^tx_word_reg[7:0];
`endif
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          tx_load      = 1'b1;
          tx_word_next = tx_word_reg >> 1;
          if (tx_bit_reg == LAST_BIT) begin
`ifdef UART_PARITY_EN
            tx_state_next  = TX_PARITY;
            tx_serial_next = tx_par_reg;
`else
            tx_state_next  = TX_STOP;
            tx_serial_next = 1'b1;
`endif
          end else begin
            tx_bit_next    = tx_bit_reg + 3'd1;
            tx_serial_next = tx_word_reg[1];
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (tx_tick) begin
          tx_state_next  = TX_STOP;
          tx_serial_next = 1'b1;
          tx_load        = 1'b1;
        end
      end
`endif
      TX_STOP: begin
        if (tx_tick) begin
          if (tx_byte_reg == LAST_BYTE) begin
            tx_state_next  = TX_DONE;
            tx_serial_next = 1'b1;
          end else begin
            tx_state_next  = TX_START;
            tx_serial_next = 1'b0;
            tx_byte_next   = tx_byte_reg + 1'b1;
            tx_load        = 1'b1;
          end
        end
      end
      default: begin
        tx_state_next  = TX_IDLE;
        tx_serial_next = 1'b1;
      end
    endcase
  end

  assign o_tx_serial = tx_serial_reg;
  assign o_tx_active = (tx_state_reg != TX_IDLE) && (tx_state_reg != TX_DONE);
  assign o_tx_done   = (tx_state_reg == TX_DONE);

  // ---------------- receive path ----------------
  rx_state_t rx_state_reg, rx_state_next;
  logic rx_sync1_reg, rx_sync2_reg, rx_prev_reg;
  logic [7:0] rx_shift_reg, rx_shift_next;
  logic [2:0] rx_bit_reg, rx_bit_next;
  logic [BCW-1:0] rx_byte_reg, rx_byte_next;
  logic [7:0] rx_buf_reg [WORD_BYTES];
  logic [WORD_W-1:0] rx_word_reg, commit_word;
  logic rx_dv_reg;
  logic rx_load, rx_half, rx_tick, byte_we, commit;
`ifdef UART_PARITY_EN
  logic rx_par_reg, rx_par_next;
`endif

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .load  (rx_load),
    .half  (rx_half),
    .tick  (rx_tick)
  );

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_sync1_reg <= 1'b1;
      rx_sync2_reg <= 1'b1;
      rx_prev_reg  <= 1'b1;
    end else begin
      rx_sync1_reg <= i_rx_serial;
      rx_sync2_reg <= rx_sync1_reg;
      rx_prev_reg  <= rx_sync2_reg;
    end
  end

  // RX state, byte assembly and the committed output word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_state_reg <= RX_IDLE;
      rx_shift_reg <= '0;
      rx_bit_reg   <= '0;
      rx_byte_reg  <= '0;
      rx_word_reg  <= '0;
      rx_dv_reg    <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_reg   <= 1'b0;
`endif
    end else begin
      rx_state_reg <= rx_state_next;
      rx_shift_reg <= rx_shift_next;
      rx_bit_reg   <= rx_bit_next;
      rx_byte_reg  <= rx_byte_next;
      rx_dv_reg    <= commit;
      if (commit) begin
        rx_word_reg <= commit_word;
      end
`ifdef UART_PARITY_EN
      rx_par_reg   <= rx_par_next;
`endif
    end
  end

  // RX next state. Any bad stop (or parity) bit drops the partial word.
  always_comb begin
    rx_state_next = rx_state_reg;
    rx_shift_next = rx_shift_reg;
    rx_bit_next   = rx_bit_reg;
    rx_byte_next  = rx_byte_reg;
    rx_load       = 1'b0;
    rx_half       = 1'b0;
    byte_we       = 1'b0;
    commit        = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_next   = rx_par_reg;
`endif
    case (rx_state_reg)
      RX_IDLE: begin
        if (rx_prev_reg && !rx_sync2_reg) begin
          rx_state_next = RX_START;
          rx_load       = 1'b1;
          rx_half       = 1'b1;
        end
      end
      RX_START: begin
        if (rx_tick) begin
          if (rx_sync2_reg) begin
            rx_state_next = RX_IDLE;
          end else begin
            rx_state_next = RX_DATA;
            rx_bit_next   = '0;
            rx_load       = 1'b1;
`ifdef UART_PARITY_EN
            rx_par_next   = 1'b0;
`endif
          end
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_load       = 1'b1;
          rx_shift_next = {rx_sync2_reg, rx_shift_reg[7:1]};
`ifdef UART_PARITY_EN
          rx_par_next   = rx_par_reg ^ rx_sync2_reg;
`endif
          if (rx_bit_reg == LAST_BIT) begin
`ifdef UART_PARITY_EN
            rx_state_next = RX_PARITY;
`else
            rx_state_next = RX_STOP;
`endif
          end else begin
            rx_bit_next = rx_bit_reg + 3'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rx_tick) begin
          if (rx_sync2_reg != rx_par_reg) begin
            rx_state_next = RX_IDLE;
            rx_byte_next  = '0;
          end else begin
            rx_state_next = RX_STOP;
            rx_load       = 1'b1;
          end
        end
      end
`endif
      RX_STOP: begin
        if (rx_tick) begin
          rx_state_next = RX_IDLE;
          if (rx_sync2_reg) begin
            byte_we = 1'b1;
            if (rx_byte_reg == LAST_BYTE) begin
              commit       = 1'b1;
              rx_byte_next = '0;
            end else begin
              rx_byte_next = rx_byte_reg + 1'b1;
            end
          end else begin
            rx_byte_next = '0;
          end
        end
      end
      default: begin
        rx_state_next = RX_IDLE;
      end
    endcase
  end

  // One buffer slot per byte; the final byte bypasses the buffer on commit.
  for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_rx_byte
    // Store a good byte into its slot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        rx_buf_reg[gi] <= '0;
      end else if (byte_we && (rx_byte_reg == BCW'(gi))) begin
        rx_buf_reg[gi] <= rx_shift_reg;
      end
    end

    if (gi == WORD_BYTES - 1) begin : g_last
      assign commit_word[gi*8 +: 8] = rx_shift_reg;
    end else begin : g_body
      assign commit_word[gi*8 +: 8] = rx_buf_reg[gi];
    end
  end

  assign o_rx_dv   = rx_dv_reg;
  assign o_rx_word = rx_word_reg;

endmodule

// File: tb/tb_uart_word_link.sv
// Directed bench for uart_word_link: loopback word, frame timing, busy ignore,
// framing error, glitch reject and reset mid-word. Honours UART_PARITY_EN.
module tb_uart_word_link;

  localparam int CPB = 16;
  localparam int WB = 16;
  localparam int FB = uart_pkg::FRAME_BITS;
  localparam int WORD_CYC = FB * WB * CPB;

  localparam logic [127:0] W1 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] W2 = 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678;
  localparam logic [127:0] W3 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
  localparam logic [127:0] W4 = 128'h0123456789ABCDEF_FEDCBA9876543210;

  logic clk = 1'b0;
  logic rst_n;
  logic tx_dv;
  logic [127:0] tx_word;
  logic tx_active, tx_serial, tx_done;
  logic rx_serial, rx_dv;
  logic [127:0] rx_word;
  logic use_loop, rx_drive;

  int checks = 0;
  int errors = 0;
  int rx_dv_seen = 0;

  always #5 clk = ~clk;

  assign rx_serial = use_loop ? tx_serial : rx_drive;

  uart_word_link #(.CLKS_PER_BIT(CPB), .WORD_BYTES(WB)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_tx_dv     (tx_dv),
    .i_tx_word   (tx_word),
    .o_tx_active (tx_active),
    .o_tx_serial (tx_serial),
    .o_tx_done   (tx_done),
    .i_rx_serial (rx_serial),
    .o_rx_dv     (rx_dv),
    .o_rx_word   (rx_word)
  );

  always @(negedge clk) if (rx_dv === 1'b1) rx_dv_seen++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one frame on the rx input; called on a falling clock edge.
  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    rx_drive = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drive = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    rx_drive = ^b;
    repeat (CPB) @(negedge clk);
`endif
    rx_drive = stop_bit;
    repeat (CPB) @(negedge clk);
    rx_drive = 1'b1;
  endtask

  task automatic rx_send_word(input logic [127:0] w);
    for (int i = 0; i < WB; i++) rx_frame(w[i*8 +: 8], 1'b1);
  endtask

  task automatic send_and_wait(input logic [127:0] w, input string tag);
    logic seen;
    @(negedge clk);
    tx_dv = 1'b1;
    tx_word = w;
    @(negedge clk);
    tx_dv = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < WORD_CYC + 50 && !seen; c++) begin
      @(negedge clk);
      if (tx_done) seen = 1'b1;
    end
    check({tag, " done"}, 128'(seen), 128'd1);
    check({tag, " word"}, rx_word, w);
    $display("tx/rx %s word %h received %h", tag, w, rx_word);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dv_cnt, done_cnt, done_at, act_gap, dv_before;
    logic [10:0] frame;

    rst_n = 1'b0;
    tx_dv = 1'b0;
    tx_word = '0;
    rx_drive = 1'b1;
    use_loop = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst serial", 128'(tx_serial), 128'd1);
    check("rst active", 128'(tx_active), 128'd0);
    check("rst done", 128'(tx_done), 128'd0);
    check("rst rx_dv", 128'(rx_dv), 128'd0);
    check("rst rx_word", rx_word, 128'd0);
    $display("reset state sampled");

    // Loopback word with frame timing and a busy-time request
    dv_cnt = 0; done_cnt = 0; done_at = -1; act_gap = 0; frame = '0;
    @(negedge clk);
    tx_dv = 1'b1;
    tx_word = W1;
    @(posedge clk);
    @(negedge clk);
    tx_dv = 1'b0;
    for (int n = 0; n < WORD_CYC + 200; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 500) begin tx_dv = 1'b1; tx_word = 128'h1; end
      if (n == 501) tx_dv = 1'b0;
      if (rx_dv) dv_cnt++;
      if (tx_done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (n < WORD_CYC && !tx_active) act_gap++;
      if (n < FB * CPB && (n % CPB) == CPB / 2) frame[n / CPB] = tx_serial;
      if (n == 0) check("start low first", 128'(tx_serial), 128'd0);
      if (n == CPB - 1) check("start low last", 128'(tx_serial), 128'd0);
      if (n == CPB) check("data bit0", 128'(tx_serial), 128'd1);
      if (n == WORD_CYC) begin
        check("done at end", 128'(tx_done), 128'd1);
        check("inactive at end", 128'(tx_active), 128'd0);
        check("idle line at end", 128'(tx_serial), 128'd1);
        check("loop word at done", rx_word, W1);
        check("rx_dv before done", 128'(dv_cnt), 128'd1);
      end
    end
    check("first byte frame", 128'(frame[8:0]), 128'h1FE);
    check("first stop bit", 128'(frame[FB-1]), 128'd1);
    check("active gap", 128'(act_gap), 128'd0);
    check("done cycle", 128'(done_at), 128'(WORD_CYC));
    check("done pulses", 128'(done_cnt), 128'd1);
    check("rx_dv pulses", 128'(dv_cnt), 128'd1);
    check("idle after word", 128'(tx_active), 128'd0);
    check("busy word ignored", rx_word, W1);
    $display("loopback word %h done after %0d cycles", rx_word, done_at);

    // Framing error on byte 5, then a clean word
    use_loop = 1'b0;
    @(negedge clk);
    dv_before = rx_dv_seen;
    for (int i = 0; i < 6; i++) rx_frame(W2[i*8 +: 8], (i == 5) ? 1'b0 : 1'b1);
    repeat (4 * CPB) @(negedge clk);
    check("framing no dv", 128'(rx_dv_seen - dv_before), 128'd0);
    check("framing word kept", rx_word, W1);
    $display("framing error injected on byte 5");
    dv_before = rx_dv_seen;
    rx_send_word(W2);
    repeat (2 * CPB) @(negedge clk);
    check("after framing word", rx_word, W2);
    check("after framing dv", 128'(rx_dv_seen - dv_before), 128'd1);
    $display("rx word %h after framing error", rx_word);

    // Glitch shorter than half a bit, then a clean word
    dv_before = rx_dv_seen;
    rx_drive = 1'b0;
    repeat (4) @(negedge clk);
    rx_drive = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch no dv", 128'(rx_dv_seen - dv_before), 128'd0);
    rx_send_word(W3);
    repeat (2 * CPB) @(negedge clk);
    check("after glitch word", rx_word, W3);
    check("after glitch dv", 128'(rx_dv_seen - dv_before), 128'd1);
    $display("rx word %h after glitch", rx_word);

    // Reset in the middle of a word, then a full transfer
    use_loop = 1'b1;
    @(negedge clk);
    tx_dv = 1'b1;
    tx_word = W4;
    @(negedge clk);
    tx_dv = 1'b0;
    repeat (1000) @(negedge clk);
    check("mid-word active", 128'(tx_active), 128'd1);
    rst_n = 1'b0;
    #1;
    check("reset serial", 128'(tx_serial), 128'd1);
    check("reset active", 128'(tx_active), 128'd0);
    check("reset done", 128'(tx_done), 128'd0);
    check("reset rx_dv", 128'(rx_dv), 128'd0);
    check("reset rx_word", rx_word, 128'd0);
    $display("reset asserted mid-word");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_and_wait(W4, "post-reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
